sync_to_mtd3l_s2p_bit_vector: RTL

- Synchronous serial-to-parallel bridge into the MTD3L (dual-rail, sleep-controlled) domain.
- Accepts one bit per clk under data_valid and assembles width-bit words, LSB first.
- Issues each word to a downstream MTD3L stage as a dual-rail wavefront, then an all-zero spacer (AZS), paced by the downstream ki handshake.
- It is the receive-side counterpart of the MTD3L-to-sync parallel-to-serial converter, so an async core can be fed from a clocked serial link.

---
 rtl/sync_to_mtd3l_s2p_bit_vector.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sync_to_mtd3l_s2p_bit_vector.sv
// Serial-to-parallel bridge from a clocked serial link into an MTD3L dual-rail stage.
// Optional S2P_MTD3L_OVERFLOW_ERR_EN adds a sticky overflow_err output and a rail-legality assertion.
module sync_to_mtd3l_s2p_bit_vector #(
  parameter int unsigned width       = 512,
  parameter int unsigned sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in,
  input  logic                 data_valid,
  output logic                 ready,
  input  logic                 ki,
  output logic [2*width-1:0]   data_out,
`ifdef S2P_MTD3L_OVERFLOW_ERR_EN
  output logic                 overflow_err,
`endif
  output logic                 sleep_out
);

  localparam int unsigned cnt_w  = (width > 1) ? $clog2(width) : 1;
  localparam int unsigned dr_w   = 2 * width;

  typedef enum logic {S_NULL, S_DATA} state_t;

  state_t               state_q, state_d;
  logic [dr_w-1:0]      data_q, data_d;
  logic                 sleep_q, sleep_d;
  logic                 pending_q, pending_d;
  logic                 ready_q;
  logic [width-1:0]     shift_q;
  logic [cnt_w-1:0]     cnt_q;
  logic [sync_stages-1:0] sync_q;
  logic                 ki_s;
  logic                 accept;
  logic                 last_bit;

  function automatic logic [dr_w-1:0] encode(input logic [width-1:0] w);
    logic [dr_w-1:0] r;
    r = '0;
    for (int i = 0; i < int'(width); i++) begin
      r[2*i+1] = w[i];
      r[2*i]   = ~w[i];
    end
    return r;
  endfunction

  assign ki_s     = sync_q[sync_stages-1];
  assign accept   = data_valid & ready_q;
  assign last_bit = (cnt_q == cnt_w'(width - 1));

  // ki synchronizer; the only consumer of raw ki
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[sync_stages-2:0], ki};
  end

  // Shift side: shift register freezes once a full word is pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shift_q[cnt_q] <= data_in;
      cnt_q          <= last_bit ? '0 : cnt_q + cnt_w'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sleep_d   = sleep_q;
    pending_d = pending_q;
    if (accept && last_bit) pending_d = 1'b1;
    case (state_q)
      S_NULL: begin
        data_d  = '0;
        sleep_d = 1'b1;
        if (pending_q && ki_s) begin
          data_d    = encode(shift_q);
          sleep_d   = 1'b0;
          pending_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (!ki_s) begin
          data_d  = '0;
          sleep_d = 1'b1;
          state_d = S_NULL;
        end
      end
      default: begin
        data_d  = '0;
        sleep_d = 1'b1;
        state_d = S_NULL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_NULL;
      data_q    <= '0;
      sleep_q   <= 1'b1;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      sleep_q   <= sleep_d;
      pending_q <= pending_d;
      ready_q   <= ~pending_d;
    end
  end

  assign data_out  = data_q;
  assign sleep_out = sleep_q;
  assign ready     = ready_q;

`ifdef S2P_MTD3L_OVERFLOW_ERR_EN
  logic overflow_q;
  logic rail11;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_q | (data_valid & ~ready_q);
  end

  assign overflow_err = overflow_q;

  always_comb begin
    rail11 = 1'b0;
    for (int i = 0; i < int'(width); i++) rail11 = rail11 | (data_q[2*i+1] & data_q[2*i]);
  end

  a_no_rail11: assert property (@(posedge clk) disable iff (reset) !rail11);
`endif

endmodule
